// File: rtl/pipe_reg.sv
// pipe_reg: DEPTH-stage valid/data pipeline register with stall, flush and occupancy count.
module pipe_reg #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           d,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           q,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int OW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] vld;
  always_ff @(posedge clk or posedge reset) begin
    if (reset || flush) begin
      for (int i = 0; i < DEPTH; i++) data[i] <= RESET_VAL;
      vld       <= '0;
      occupancy <= '0;
    end else if (!stall) begin
      data[0] <= in_valid ? d : RESET_VAL;
      vld[0]  <= in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        data[i] <= data[i-1];
        vld[i]  <= vld[i-1];
      end
      // occupancy tracks popcount: one entry in, the last-stage entry out
      occupancy <= occupancy + OW'(in_valid) - OW'(vld[DEPTH-1]);
    end
  end
  assign q         = data[DEPTH-1];
  assign out_valid = vld[DEPTH-1];
endmodule

// File: tb/tb_pipe_reg.sv
// tb_pipe_reg: directed vector table for a 3-deep byte pipe plus hand sequences for async reset and the DEPTH=1 case.
module tb_pipe_reg;
  logic clk = 0;
  always #5 clk = ~clk;
  logic reset, stall, flush, in_valid;
  logic [7:0] d, q;
  logic out_valid;
  logic [1:0] occupancy;
  logic reset2, stall2, flush2, iv2, ov2;
  logic [31:0] d2, q2;
  logic occ2;
  int ncmp = 0, nerr = 0;

  pipe_reg #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .d(d), .out_valid(out_valid), .q(q), .occupancy(occupancy));

  pipe_reg #(.WIDTH(32), .DEPTH(1), .RESET_VAL(32'hDEADBEEF)) dut1 (
    .clk(clk), .reset(reset2), .stall(stall2), .flush(flush2), .in_valid(iv2),
    .d(d2), .out_valid(ov2), .q(q2), .occupancy(occ2));

  typedef struct {
    logic rst, stl, fl, iv;
    logic [7:0] d, eq;
    logic ev;
    logic [1:0] eo;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t mk(logic rst, logic stl, logic fl, logic iv, logic [7:0] dd,
                              logic [7:0] eq, logic ev, logic [1:0] eo);
    vec_t v;
    v.rst = rst; v.stl = stl; v.fl = fl; v.iv = iv; v.d = dd;
    v.eq = eq; v.ev = ev; v.eo = eo;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk8(string tag, logic [7:0] eq, logic ev, logic [1:0] eo);
    chk({tag, ".q"}, 32'(q), 32'(eq));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
    chk({tag, ".occupancy"}, 32'(occupancy), 32'(eo));
  endtask

  initial begin
    reset = 1; stall = 0; flush = 0; in_valid = 0; d = 0;
    reset2 = 1; stall2 = 0; flush2 = 0; iv2 = 0; d2 = 0;
    //            rst stl fl iv  d      q      v  occ
    tv.push_back(mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0));
    tv.push_back(mk(0, 0, 0, 1, 8'h11, 8'h00, 0, 1));
    tv.push_back(mk(0, 0, 0, 1, 8'h22, 8'h00, 0, 2));
    tv.push_back(mk(0, 0, 0, 1, 8'h33, 8'h11, 1, 3));
    tv.push_back(mk(0, 0, 0, 0, 8'h00, 8'h22, 1, 2));
    tv.push_back(mk(0, 0, 0, 0, 8'h00, 8'h33, 1, 1));
    tv.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 0, 0));
    tv.push_back(mk(0, 0, 0, 1, 8'h11, 8'h00, 0, 1));
    tv.push_back(mk(0, 0, 0, 1, 8'h22, 8'h00, 0, 2));
    tv.push_back(mk(0, 0, 0, 1, 8'h33, 8'h11, 1, 3));
    tv.push_back(mk(0, 1, 0, 1, 8'h44, 8'h11, 1, 3));
    tv.push_back(mk(0, 1, 0, 1, 8'h44, 8'h11, 1, 3));
    tv.push_back(mk(0, 0, 0, 0, 8'h00, 8'h22, 1, 2));
    tv.push_back(mk(0, 0, 0, 1, 8'h44, 8'h33, 1, 2));
    tv.push_back(mk(0, 0, 0, 1, 8'h55, 8'h00, 0, 2));
    tv.push_back(mk(0, 0, 0, 1, 8'h66, 8'h44, 1, 3));
    tv.push_back(mk(0, 1, 1, 1, 8'h77, 8'h00, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 0, 0));
    tv.push_back(mk(0, 0, 0, 1, 8'hAA, 8'h00, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 8'hFF, 8'h00, 0, 1));
    tv.push_back(mk(0, 0, 0, 1, 8'hBB, 8'hAA, 1, 2));
    tv.push_back(mk(0, 0, 0, 0, 8'hFF, 8'h00, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 8'h00, 8'hBB, 1, 1));
    tv.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 0, 0));
    tv.push_back(mk(0, 0, 0, 1, 8'h11, 8'h00, 0, 1));
    tv.push_back(mk(0, 0, 0, 1, 8'h22, 8'h00, 0, 2));
    tv.push_back(mk(0, 0, 0, 1, 8'h33, 8'h11, 1, 3));
    #1;
    chk8("reset0", 8'h00, 0, 0);
    foreach (tv[i]) begin
      reset = tv[i].rst; stall = tv[i].stl; flush = tv[i].fl;
      in_valid = tv[i].iv; d = tv[i].d;
      @(posedge clk); #1;
      chk8($sformatf("vec%0d", i), tv[i].eq, tv[i].ev, tv[i].eo);
    end
    in_valid = 0; d = 0;
    // async reset midway between edges, checked before the next rising edge
    #3 reset = 1;
    #1 chk8("async_reset", 8'h00, 0, 0);
    @(negedge clk) reset = 0; stall = 1; in_valid = 1; d = 8'h5A;
    @(posedge clk); #1 chk8("post_reset_stall", 8'h00, 0, 0);
    stall = 0;
    @(posedge clk); #1 chk8("first_capture", 8'h00, 0, 1);
    in_valid = 0;
    @(posedge clk); #1 chk8("first_capture2", 8'h00, 0, 1);
    @(posedge clk); #1 chk8("first_capture3", 8'h5A, 1, 1);

    chk("d1.reset.q", q2, 32'hDEADBEEF);
    chk("d1.reset.v", 32'(ov2), 0);
    chk("d1.reset.occ", 32'(occ2), 0);
    reset2 = 0; iv2 = 1; d2 = 32'h1;
    @(posedge clk); #1;
    chk("d1.push.q", q2, 32'h1);
    chk("d1.push.v", 32'(ov2), 1);
    chk("d1.push.occ", 32'(occ2), 1);
    stall2 = 1; d2 = 32'h2;
    @(posedge clk); #1;
    chk("d1.stall.q", q2, 32'h1);
    stall2 = 0; iv2 = 0;
    @(posedge clk); #1;
    chk("d1.bubble.q", q2, 32'hDEADBEEF);
    chk("d1.bubble.occ", 32'(occ2), 0);
    iv2 = 1; d2 = 32'h5;
    @(posedge clk); #1;
    chk("d1.push5.q", q2, 32'h5);
    flush2 = 1; d2 = 32'h9;
    @(posedge clk); #1;
    chk("d1.flush.q", q2, 32'hDEADBEEF);
    chk("d1.flush.v", 32'(ov2), 0);
    chk("d1.flush.occ", 32'(occ2), 0);
    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/pipe_reg.md
PIPE_REG -- requirements
Module: pipe_reg

Interface
REQ-001 Parameter WIDTH, default 9, data width in bits of each stage (WIDTH >= 1).
REQ-002 Parameter DEPTH, default 1, number of register stages (DEPTH >= 1).
REQ-003 Parameter RESET_VAL, default 0, WIDTH-bit value loaded into data registers on reset, flush and bubbles.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 stall  input  1  freeze all stages when high.
REQ-007 flush  input  1  synchronous kill of all stages when high.
REQ-008 in_valid  input  1  d carries a valid entry this cycle.
REQ-009 d  input  WIDTH  stage-0 input data.
REQ-010 out_valid  output  1  valid bit of the last stage.
REQ-011 q  output  WIDTH  data of the last stage.
REQ-012 occupancy  output  $clog2(DEPTH+1)  count of valid stages, registered.

Function
REQ-013 The block SHALL hold DEPTH stages, each a WIDTH-bit data register plus a 1-bit valid register.
REQ-014 q and out_valid SHALL be driven directly from the last stage's registers, with no combinational path from any input.
REQ-015 Edge priority SHALL be: reset > flush > stall > advance.
REQ-016 On flush: at the next edge all valid bits clear, all data registers load RESET_VAL and occupancy becomes 0; stall, in_valid and d are ignored that cycle.
REQ-017 On stall without flush: every stage, and occupancy, holds its value; in_valid and d are not captured, so the upstream must hold them.
REQ-018 On advance (neither stall nor flush): stage 0 loads {in_valid, d} and stage i loads stage i-1 for i = 1..DEPTH-1.
REQ-019 On advance with in_valid = 0, stage 0 data SHALL load RESET_VAL (bubbles are zeroed), not d.
REQ-020 Latency SHALL be exactly DEPTH advancing edges from capture to appearance on q/out_valid; stalled cycles add latency one for one.
REQ-021 On advance, occupancy SHALL change by in_valid minus (last-stage valid before the edge), without wrapping.
REQ-022 occupancy SHALL always equal the population count of the valid bits; with WIDTH-accurate saturation it never exceeds DEPTH.
REQ-023 An entry leaving the last stage on an advance edge is dropped; there is no downstream backpressure other than stall.
REQ-024 With DEPTH = 1 the block SHALL behave as a single resettable register with enable (~stall) and synchronous clear (flush), plus valid and occupancy.
REQ-025 Simultaneous stall and flush SHALL flush.

Reset
REQ-026 While reset is high, all valid bits, out_valid and occupancy SHALL be 0 and all data registers and q SHALL be RESET_VAL, immediately and without waiting for a clock edge.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight entries.
REQ-028 The first capture after reset deasserts SHALL occur on the first rising edge at which reset is low and stall and flush are low.

Verification (WIDTH = 8, DEPTH = 3, RESET_VAL = 0 unless stated)
REQ-029 Fill: after reset, present in_valid = 1 with d = 0x11, 0x22, 0x33 on edges 1-3 -> occupancy reads 1, 2, 3 after those edges; after edge 3, q = 0x11 and out_valid = 1; after edges 4 and 5 (in_valid = 0), q = 0x22 then 0x33.
REQ-030 Stall: with the pipe holding 0x11/0x22/0x33, raise stall for 2 edges -> q stays 0x11 and occupancy stays 3; on release, q = 0x22 after the next edge.
REQ-031 Flush with stall: with the pipe full, assert flush and stall together for one edge -> after that edge out_valid = 0, q = 0x00 and occupancy = 0.
REQ-032 Bubble: push 0xAA, bubble (in_valid = 0 with d = 0xFF), then 0xBB -> q sequence 0xAA/valid, 0x00/invalid, 0xBB/valid; occupancy never exceeds 2.
REQ-033 Async reset: with the pipe full, assert reset midway between edges -> q = 0x00, out_valid = 0 and occupancy = 0 before the next rising edge.
REQ-034 Degenerate case (DEPTH = 1, WIDTH = 32, RESET_VAL = 0xDEADBEEF): after reset q = 0xDEADBEEF; a push of 0x1 appears after 1 edge; flush restores 0xDEADBEEF.
